// File: rtl/inst_fetch_bridge.sv
// Instruction-fetch front end: direct-mapped one-word-per-line cache in front of a req/ack bus.
// Misses stall the core until the line is filled; a bus error hands the core a single NOP.
module inst_fetch_bridge #(
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce,
  input  logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_data,
  output logic              stallreq_if,
  input  logic              inv_i,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_err,
  output logic [31:0]       miss_cnt,
  output logic [1:0]        dbg_state
);
  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [31:0]       miss_cnt_q, miss_cnt_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  logic [IDX_W-1:0]  idx, fill_idx;
  logic [TAG_W-1:0]  tag;
  logic              hit, fill_en;
  logic              unused_addr_bits;

  assign idx              = rom_addr[IDX_W+1:2];
  assign tag              = rom_addr[ADDR_W-1:IDX_W+2];
  assign fill_idx         = bus_addr_q[IDX_W+1:2];
  assign hit              = rom_ce & valid_q[idx] & (tag_q[idx] == tag);
  assign unused_addr_bits = ^rom_addr[1:0];

  // Bus handshake: bus_req rises with bus_addr and both hold steady until the
  // bus returns a one-cycle bus_ack (bus_rdata/bus_err valid only in that cycle);
  // bus_req drops in the cycle after bus_ack.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    miss_cnt_d  = miss_cnt_q;
    fill_en     = 1'b0;
    stallreq_if = 1'b0;
    rom_data    = '0;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          rom_data = data_q[idx];
        end else if (rom_ce) begin
          stallreq_if = 1'b1;
          bus_addr_d  = {rom_addr[ADDR_W-1:2], 2'b00};
          bus_req_d   = 1'b1;
          state_d     = S_REQ;
          if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
        end
      end
      S_REQ: begin
        stallreq_if = rom_ce;
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (bus_err) begin
            state_d = S_ERR;
          end else begin
            fill_en = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Invalidate beats a coincident fill so stale code can never survive it.
  always_comb begin
    valid_d = inv_i ? '0 : valid_q;
    if (fill_en && !inv_i) valid_d[fill_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      bus_req_q  <= 1'b0;
      bus_addr_q <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      bus_req_q  <= bus_req_d;
      bus_addr_q <= bus_addr_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= bus_addr_q[ADDR_W-1:IDX_W+2];
      data_q[fill_idx] <= bus_rdata;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_addr  = bus_addr_q;
  assign miss_cnt  = miss_cnt_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge: fetch driver with inline bus responder,
// scoreboard monitor checking every completed fetch against an expected queue.
module tb_inst_fetch_bridge;
  logic        clk;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        stallreq_if;
  logic        inv_i;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic [31:0] miss_cnt;
  logic [1:0]  dbg_state;

  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  inst_fetch_bridge #(.IDX_W(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr),
    .rom_data(rom_data), .stallreq_if(stallreq_if), .inv_i(inv_i),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .bus_err(bus_err), .miss_cnt(miss_cnt),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every fetch the core consumes is compared with the queue head
  always @(negedge clk) begin
    if (rst === 1'b1 && rom_ce === 1'b1 && stallreq_if === 1'b0) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_fetch: got %h expected none", rom_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rom_data !== e) begin
          n_err++;
          $display("FAIL fetch_data@%h: got %h expected %h", rom_addr, rom_data, e);
        end
      end
    end
  end

  // drives one fetch to completion, acking each bus request on its lat-th REQ cycle
  task automatic fetch(input logic [31:0] addr, input int lat, input logic [31:0] rdata,
                       input bit err, input bit inv_ack, input int exp_stalls,
                       input logic [31:0] exp_data);
    int  stalls = 0;
    int  req_cycles = 0;
    bit  done = 0;
    bit  inv_pend = inv_ack;
    rom_ce   = 1'b1;
    rom_addr = addr;
    exp_q.push_back(exp_data);
    for (int cyc = 0; cyc < 50 && !done; cyc++) begin
      @(negedge clk);
      if (stallreq_if) stalls++;
      else done = 1;
      if (bus_req) begin
        req_cycles++;
        if (req_cycles == 1) chk("bus_addr", bus_addr, {addr[31:2], 2'b00});
        if (req_cycles == lat) begin
          bus_ack   = 1'b1;
          bus_rdata = rdata;
          bus_err   = err;
          inv_i     = inv_pend;
          inv_pend  = 0;
        end
      end else begin
        req_cycles = 0;
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
      bus_err = 1'b0;
      inv_i   = 1'b0;
    end
    rom_ce = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL fetch_timeout@%h: got no completion expected completion", addr);
    end
    chk("stall_cycles", stalls, exp_stalls);
  endtask

  initial begin
    rst = 1'b0; rom_ce = 1'b0; rom_addr = '0; inv_i = 1'b0;
    bus_ack = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    chk("rst_stall", {31'd0, stallreq_if}, 32'd0);
    chk("rst_rom_data", rom_data, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // cold miss, sequential hit/miss, low address bits ignored
    fetch(32'h0, 3, 32'h3401_1100, 0, 0, 4, 32'h3401_1100);
    chk("miss_cnt_cold", miss_cnt, 32'd1);
    fetch(32'h0, 1, 32'hDEAD_0000, 0, 0, 0, 32'h3401_1100);
    fetch(32'h4, 1, 32'h2402_0004, 0, 0, 2, 32'h2402_0004);
    chk("miss_cnt_seq", miss_cnt, 32'd2);
    fetch(32'h7, 1, 32'hDEAD_0007, 0, 0, 0, 32'h2402_0004);

    // conflict eviction on index 0
    fetch(32'h40, 2, 32'hAAAA_0040, 0, 0, 3, 32'hAAAA_0040);
    fetch(32'h0, 1, 32'h3401_1100, 0, 0, 2, 32'h3401_1100);
    chk("miss_cnt_conflict", miss_cnt, 32'd4);
    fetch(32'h0, 1, 32'hDEAD_0000, 0, 0, 0, 32'h3401_1100);

    // bus error: one NOP, then the line is still invalid
    fetch(32'h100, 1, 32'h5555_5555, 1, 0, 2, 32'h0);
    chk("state_after_err", {30'd0, dbg_state}, 32'd0);
    fetch(32'h100, 1, 32'h1111_0100, 0, 0, 2, 32'h1111_0100);
    chk("miss_cnt_err", miss_cnt, 32'd6);

    // invalidate coinciding with fill: first fill lost, second miss refills
    fetch(32'h8, 1, 32'h0808_0808, 0, 1, 4, 32'h0808_0808);
    chk("miss_cnt_inv_fill", miss_cnt, 32'd8);
    fetch(32'h8, 1, 32'hDEAD_0008, 0, 0, 0, 32'h0808_0808);

    // standalone invalidate clears everything
    inv_i = 1'b1;
    @(posedge clk); #1;
    inv_i = 1'b0;
    fetch(32'h0, 1, 32'h3401_1100, 0, 0, 2, 32'h3401_1100);
    chk("miss_cnt_inv", miss_cnt, 32'd9);

    // rom_ce drops and rom_addr moves during REQ; fill still lands at the latched address
    rom_ce = 1'b1; rom_addr = 32'hC;
    @(negedge clk);
    chk("ce_drop_miss_stall", {31'd0, stallreq_if}, 32'd1);
    @(posedge clk); #1;
    rom_ce = 1'b0; rom_addr = 32'h20;
    @(negedge clk);
    chk("ce_drop_stall", {31'd0, stallreq_if}, 32'd0);
    chk("ce_drop_bus_req", {31'd0, bus_req}, 32'd1);
    chk("ce_drop_bus_addr", bus_addr, 32'hC);
    bus_ack = 1'b1; bus_rdata = 32'h0C0C_0C0C;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("ce_drop_req_fall", {31'd0, bus_req}, 32'd0);
    chk("miss_cnt_ce_drop", miss_cnt, 32'd10);
    @(posedge clk); #1;
    fetch(32'hC, 1, 32'hDEAD_000C, 0, 0, 0, 32'h0C0C_0C0C);

    // reset in the middle of a request
    rom_ce = 1'b1; rom_addr = 32'h10;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_bus_req", {31'd0, bus_req}, 32'd1);
    rom_ce = 1'b0;
    rst = 1'b0;
    #1;
    chk("midreq_rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("midreq_rst_miss_cnt", miss_cnt, 32'd0);
    chk("midreq_rst_bus_addr", bus_addr, 32'd0);
    chk("midreq_rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    fetch(32'hC, 1, 32'h0C0C_0C0C, 0, 0, 2, 32'h0C0C_0C0C);
    fetch(32'h0, 1, 32'h3401_1100, 0, 0, 2, 32'h3401_1100);
    chk("miss_cnt_post_rst", miss_cnt, 32'd2);

    repeat (3) @(posedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/inst_fetch_bridge.md
Name: inst_fetch_bridge

Overview:
- Sits directly upstream of the CPU core's instruction-fetch port (rom_ce / rom_addr / rom_data).
- Serves fetches from a small direct-mapped, one-word-per-line instruction cache.
- On a miss, it fetches the word from a slower req/ack instruction bus.
- While the miss is outstanding, it raises a stall request toward the pipeline controller so the PC and IF/ID registers hold.

Parameters:
- IDX_W, 4, log2 of the number of cache lines (16 lines by default).
- ADDR_W, 32, instruction address width; same as pc_t.
- DATA_W, 32, instruction width; same as inst_t.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-low (asserted when 0).
- rom_ce  input  1  fetch enable from the core (chip enabled = 1).
- rom_addr  input  ADDR_W  fetch address (PC) from the core.
- rom_data  output  DATA_W  instruction returned to the core.
- stallreq_if  output  1  stall request to the pipeline controller; 1 while the fetch cannot complete this cycle.
- inv_i  input  1  invalidate all cache lines (e.g. after self-modifying code).
- bus_req  output  1  instruction-bus read request.
- bus_addr  output  ADDR_W  word-aligned bus read address.
- bus_ack  input  1  bus read complete; bus_rdata/bus_err valid this cycle.
- bus_rdata  input  DATA_W  bus read data.
- bus_err  input  1  bus error, qualified by bus_ack.
- miss_cnt  output  32  saturating count of cache misses since reset.

Behaviour:
- Address split:
  - index = rom_addr[IDX_W+1:2].
  - tag = rom_addr[ADDR_W-1:IDX_W+2].
  - rom_addr[1:0] is ignored.
- Storage per line: valid bit, tag, DATA_W data.
- Lookup is combinational. hit = rom_ce & valid[index] & (tag_store[index] == tag).
- rom_ce = 0: rom_data = 0, stallreq_if = 0, no bus request issued.
- FSM states: IDLE, REQ, ERR.
- IDLE:
  - On hit: rom_data = line data in the same cycle, stallreq_if = 0.
  - On miss (rom_ce = 1, not hit): stallreq_if = 1 combinationally, the word-aligned address is latched, miss_cnt increments (saturates at 32'hFFFF_FFFF), go to REQ.
  - rom_data = 0 while missing.
- REQ:
  - bus_req = 1 and bus_addr = latched address, held stable until bus_ack.
  - stallreq_if = 1 while rom_ce = 1.
  - On bus_ack with bus_err = 0: write the line (valid = 1, tag, data) at the latched index and go to IDLE. The next cycle's lookup hits.
  - On bus_ack with bus_err = 1: no line write, go to ERR.
  - Minimum miss penalty: 2 stall cycles when the bus acks in its first REQ cycle.
- ERR (one cycle only):
  - rom_data = 32'h0000_0000 (NOP) and stallreq_if = 0, so the core consumes a NOP.
  - Return to IDLE. The line stays invalid.
- bus_req is deasserted in the cycle after bus_ack. A new request may start in the following IDLE cycle.
- rom_ce falling during REQ: the bus transaction is not abandoned; it completes and fills the line. stallreq_if follows rom_ce = 0 immediately (0).
- rom_addr changing during REQ: the latched address is used for the fill. After return to IDLE, the new address is looked up afresh (it may miss again).
- inv_i: all valid bits clear at the next edge.
  - If it coincides with a fill, invalidate wins and the filled line is also invalid.
  - inv_i does not disturb the FSM or an outstanding bus request.
- Reset (rst = 0, asynchronous):
  - All valid bits 0, FSM = IDLE, bus_req = 0, bus_addr = 0, miss_cnt = 0.
  - rom_data and stallreq_if = 0 (combinational from the reset state with rom_ce gating).
  - Reset mid-REQ drops the request; the bus must tolerate it.
- Tag and data arrays need no reset. Only the valid bits are reset.

Test Plan:
- Cold miss:
  - Stimulus: after reset, rom_ce = 1, rom_addr = 0x0000_0000; bus acks on its 3rd REQ cycle with 0x3401_1100.
  - Response: stallreq_if = 1 for 4 cycles, bus_addr = 0; next cycle rom_data = 0x3401_1100, stallreq_if = 0, miss_cnt = 1.
- Sequential hit:
  - Stimulus: refetch 0x0 after the fill; then fetch 0x4, which misses.
  - Response: 0x0 returns data with zero stall; 0x4 misses and miss_cnt = 2.
- Conflict eviction:
  - Stimulus: fill 0x0000_0000, then fetch 0x0000_0040 (same index 0, different tag), then 0x0 again.
  - Response: both fetches miss; miss_cnt increments twice.
- Bus error:
  - Stimulus: a miss at 0x100 is acked with bus_err = 1.
  - Response: exactly one cycle with rom_data = 0, stallreq_if = 0; refetching 0x100 misses again.
- Invalidate during fill:
  - Stimulus: inv_i = 1 in the same cycle as bus_ack for 0x8.
  - Response: the line stays invalid; fetching 0x8 misses again.
- Reset and enable gating:
  - Stimulus: drop rst to 0 while in REQ; separately, set rom_ce = 0 during REQ.
  - Response: on reset, bus_req falls immediately, miss_cnt = 0, and all fetches miss afterwards. With rom_ce = 0, stallreq_if = 0, the fill still completes, and a later fetch of that address hits.
